icache_ctrl: RTL and testbench

//   Direct-mapped, read-only instruction cache between fetch (pif) and instruction memory.

---
 rtl/icache_pkg.sv | 27 ++
 rtl/icache_data_array.sv | 33 +++
 rtl/icache_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_icache_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the instruction cache.
// Address split: tag | index | word | byte.
package icache_pkg;

    localparam int COMMON_WIDTH   = 32;
    localparam int DEF_NUM_LINES  = 64;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } icache_state_t;

    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_bits(input int num_lines, input int line_words);
        return COMMON_WIDTH - idx_bits(num_lines) - off_bits(line_words) - 2;
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction cache data storage: NUM_LINES x LINE_WORDS words.
// Combinational read port, one synchronous write port.
module icache_data_array
    import icache_pkg::*;
#(
    parameter  int NUM_LINES  = DEF_NUM_LINES,
    parameter  int LINE_WORDS = DEF_LINE_WORDS,
    localparam int OFF        = off_bits(LINE_WORDS),
    localparam int IDX        = idx_bits(NUM_LINES)
) (
    input  logic                    clk,
    input  logic [IDX-1:0]          rd_index,
    input  logic [OFF-1:0]          rd_word,
    output logic [COMMON_WIDTH-1:0] rd_data,
    input  logic                    we,
    input  logic [IDX-1:0]          wr_index,
    input  logic [OFF-1:0]          wr_word,
    input  logic [COMMON_WIDTH-1:0] wr_data
);

    logic [COMMON_WIDTH-1:0] mem [NUM_LINES*LINE_WORDS];

    // Read is purely combinational so a hit can be registered in one cycle.
    assign rd_data = mem[{rd_index, rd_word}];

    // Refill beats write one word per memory completion.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_index, wr_word}] <= wr_data;
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller.
// Hits answer in one cycle; misses refill a whole line in order.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = DEF_NUM_LINES,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    read_flag,
    input  logic [COMMON_WIDTH-1:0] addr,
    input  logic                    flush,
    output logic [COMMON_WIDTH-1:0] read_data,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_read,
    output logic [COMMON_WIDTH-1:0] mem_addr,
    input  logic [COMMON_WIDTH-1:0] mem_rdata,
    input  logic                    mem_done
);

    localparam int OFF  = off_bits(LINE_WORDS);
    localparam int IDX  = idx_bits(NUM_LINES);
    localparam int TAGW = tag_bits(NUM_LINES, LINE_WORDS);
    localparam logic [OFF-1:0] LAST_WORD = OFF'(LINE_WORDS - 1);

    icache_state_t state, state_n;

    logic [OFF-1:0]          a_word;
    logic [IDX-1:0]          a_idx;
    logic [TAGW-1:0]         a_tag;
    logic                    unused_addr;

    logic [NUM_LINES-1:0]    valid;
    logic [TAGW-1:0]         tags [NUM_LINES];

    logic [OFF-1:0]          count;
    logic [TAGW-1:0]         lat_tag;
    logic [IDX-1:0]          lat_idx;
    logic [OFF-1:0]          lat_word;
    logic [COMMON_WIDTH-1:0] cap_word;
    logic                    flush_pend;

    logic                    hit;
    logic                    beat;
    logic                    last;
    logic [COMMON_WIDTH-1:0] rd_data;

    assign a_word      = addr[OFF+1:2];
    assign a_idx       = addr[IDX+OFF+1:OFF+2];
    assign a_tag       = addr[COMMON_WIDTH-1:IDX+OFF+2];
    assign unused_addr = ^addr[1:0];

    // A flush in the same cycle as a lookup forces a miss.
    assign hit  = valid[a_idx] && (tags[a_idx] == a_tag) && !flush;
    assign beat = (state == REFILL) && mem_read && mem_done;
    assign last = beat && (count == LAST_WORD);

    icache_data_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_data (
        .clk      (clk),
        .rd_index (a_idx),
        .rd_word  (a_word),
        .rd_data  (rd_data),
        .we       (beat),
        .wr_index (lat_idx),
        .wr_word  (count),
        .wr_data  (mem_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (read_flag && !hit) begin
                    state_n = REFILL;
                end
            end
            REFILL: begin
                if (last) begin
                    state_n = RESPOND;
                end
            end
            RESPOND: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Tag store; written once per completed refill.
    always_ff @(posedge clk) begin
        if (last) begin
            tags[lat_idx] <= lat_tag;
        end
    end

    // Registered outputs, valid bits and refill bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            count      <= '0;
            lat_tag    <= '0;
            lat_idx    <= '0;
            lat_word   <= '0;
            cap_word   <= '0;
            flush_pend <= 1'b0;
            read_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                valid <= '0;
            end
            unique case (state)
                IDLE: begin
                    flush_pend <= 1'b0;
                    if (read_flag) begin
                        if (hit) begin
                            done      <= 1'b1;
                            read_data <= rd_data;
                        end else begin
                            lat_tag  <= a_tag;
                            lat_idx  <= a_idx;
                            lat_word <= a_word;
                            count    <= '0;
                            busy     <= 1'b1;
                            mem_read <= 1'b1;
                            mem_addr <= {a_tag, a_idx, {OFF{1'b0}}, 2'b00};
                        end
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (beat) begin
                        if (count == lat_word) begin
                            cap_word <= mem_rdata;
                        end
                        if (last) begin
                            mem_read <= 1'b0;
                            // A flush seen at any point of the refill leaves the line invalid.
                            if (!flush_pend && !flush) begin
                                valid[lat_idx] <= 1'b1;
                            end
                        end else begin
                            count    <= count + OFF'(1);
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                RESPOND: begin
                    done      <= 1'b1;
                    read_data <= cap_word;
                    busy      <= 1'b0;
                end
                default: begin
                    busy     <= 1'b0;
                    mem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: table-driven hit vectors plus
// hand-written miss, eviction, flush and reset sequences.
module tb_icache_ctrl;

    logic        clk;
    logic        rst;
    logic        read_flag;
    logic [31:0] addr;
    logic        flush;
    logic [31:0] read_data;
    logic        busy;
    logic        done;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int beats = 0;
    int last_beat_cyc = 0;
    int gen = 0;
    logic [31:0] addr_q [$];

    icache_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .read_flag (read_flag),
        .addr      (addr),
        .flush     (flush),
        .read_data (read_data),
        .busy      (busy),
        .done      (done),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory contents: address-derived, with a generation tag to model rewrites.
    function automatic logic [31:0] mword(input logic [31:0] a, input int g);
        return (a >> 2) + 32'h60 + 32'(g) * 32'h1000;
    endfunction

    // Memory responder: three cycles of wait per word, one-cycle mem_done.
    initial begin
        int wc;
        wc = 0;
        mem_done = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_done) begin
                mem_done = 1'b0;
                beats++;
                last_beat_cyc = cyc;
            end
            if (rst || !mem_read) begin
                wc = 0;
            end else begin
                wc++;
                if (wc == 3) begin
                    mem_done = 1'b1;
                    mem_rdata = mword(mem_addr, gen);
                    addr_q.push_back(mem_addr);
                    wc = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic do_miss(input logic [31:0] a, input logic [31:0] exp,
                           input int flush_beat, input logic flush_req);
        int b0;
        int q0;
        int busy_bad;
        int n;
        bit got;
        bit fl_done;
        logic [31:0] base;
        base = a & ~32'hF;
        b0 = beats;
        q0 = addr_q.size();
        busy_bad = 0;
        got = 1'b0;
        fl_done = 1'b0;
        @(negedge clk);
        read_flag = 1'b1;
        addr = a;
        flush = flush_req;
        @(negedge clk);
        read_flag = 1'b0;
        flush = 1'b0;
        chk("miss_busy", 32'(busy), 32'd1);
        chk("miss_mem_read", 32'(mem_read), 32'd1);
        chk("miss_mem_addr", mem_addr, base);
        chk("miss_no_done", 32'(done), 32'd0);
        for (int t = 0; t < 200 && !got; t++) begin
            if (flush_beat >= 0 && !fl_done && (beats - b0) == flush_beat) begin
                flush = 1'b1;
                fl_done = 1'b1;
            end
            @(negedge clk);
            flush = 1'b0;
            if (done) got = 1'b1;
            else if (!busy) busy_bad++;
        end
        chk("miss_done_seen", 32'(got), 32'd1);
        chk("miss_data", read_data, exp);
        chk("miss_busy_low", 32'(busy), 32'd0);
        chk("miss_mem_read_low", 32'(mem_read), 32'd0);
        chk("miss_busy_held", 32'(busy_bad), 32'd0);
        chk("miss_beats", 32'(beats - b0), 32'd4);
        // done falls in the second cycle after the last mem_done cycle
        chk("miss_latency", 32'(cyc - last_beat_cyc), 32'd1);
        n = addr_q.size() - q0;
        chk("miss_addr_count", 32'(n), 32'd4);
        for (int i = 0; i < n && i < 4; i++) begin
            chk("miss_addr_step", addr_q[q0+i], base + 32'(4 * i));
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    typedef struct {
        logic        rf;
        logic [31:0] a;
        logic        e_done;
        logic [31:0] e_data;
        logic        e_busy;
        logic        e_mrd;
    } vec_t;

    vec_t vt [11];

    initial begin
        int b0;
        vt[0]  = '{1'b1, 32'h108, 1'b1, 32'hA2, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 32'h108, 1'b0, 32'h0,  1'b0, 1'b0};
        vt[2]  = '{1'b1, 32'h100, 1'b1, 32'hA0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 32'h104, 1'b1, 32'hA1, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 32'h108, 1'b1, 32'hA2, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 32'h10C, 1'b1, 32'hA3, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 32'h10E, 1'b1, 32'hA3, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 32'h108, 1'b1, 32'hA2, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 32'h105, 1'b1, 32'hA1, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 32'h100, 1'b1, 32'hA0, 1'b0, 1'b0};
        vt[10] = '{1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b0};

        rst = 1'b1;
        read_flag = 1'b0;
        addr = '0;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        // cold miss
        do_miss(32'h100, 32'hA0, -1, 1'b0);

        // hit after fill, then streaming hits on consecutive cycles
        b0 = beats;
        @(negedge clk);
        read_flag = vt[0].rf;
        addr = vt[0].a;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("vec_done", 32'(done), 32'(vt[i].e_done));
            if (vt[i].e_done) chk("vec_data", read_data, vt[i].e_data);
            chk("vec_busy", 32'(busy), 32'(vt[i].e_busy));
            chk("vec_mem_read", 32'(mem_read), 32'(vt[i].e_mrd));
            if (i + 1 < 11) begin
                read_flag = vt[i+1].rf;
                addr = vt[i+1].a;
            end else begin
                read_flag = 1'b0;
            end
        end
        chk("hits_no_beats", 32'(beats - b0), 32'd0);

        // conflict eviction: same index, new tag, then back
        do_miss(32'h500, mword(32'h500, 0), -1, 1'b0);
        do_miss(32'h100, 32'hA0, -1, 1'b0);

        // flush in idle, memory rewritten underneath
        gen = 1;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        do_miss(32'h100, mword(32'h100, 1), -1, 1'b0);

        // request with flush in the same cycle on a valid line misses
        gen = 2;
        do_miss(32'h104, mword(32'h104, 2), -1, 1'b1);

        // flush during refill: data delivered, line left invalid
        do_miss(32'h208, mword(32'h208, 2), 1, 1'b0);
        do_miss(32'h200, mword(32'h200, 2), -1, 1'b0);

        // reset after the second refill beat
        b0 = beats;
        @(negedge clk);
        read_flag = 1'b1;
        addr = 32'h304;
        @(negedge clk);
        read_flag = 1'b0;
        for (int t = 0; t < 100 && (beats - b0) < 2; t++) begin
            @(negedge clk);
        end
        chk("rst_mid_two_beats", 32'(beats - b0), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        do_miss(32'h304, mword(32'h304, 2), -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
